// File: rtl/fifo_1r1w_serialize_drain.sv
// Pops wide words from a 1r1w FIFO head and emits them as width_p chunks.
// Define FIFO_SERIALIZE_DRAIN_MSB_FIRST_EN to send the MSB chunk first.
module fifo_1r1w_serialize_drain #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [width_p*els_p-1:0] data_i,
    output logic                     yumi_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     last_o,
    input  logic                     ready_i
);

    localparam int cw = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [cw-1:0] last_idx = cw'(els_p - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                     state, state_n;
    logic [width_p*els_p-1:0]   word_r, word_n;
    logic [cw-1:0]              cnt_r, cnt_n;
    logic [width_p-1:0]         chunk;
    logic                       send;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state  <= IDLE;
            word_r <= '0;
            cnt_r  <= '0;
        end else begin
            state  <= state_n;
            word_r <= word_n;
            cnt_r  <= cnt_n;
        end
    end

    // The final accepted chunk may reload the next word with no bubble.
    always_comb begin
        state_n = state;
        word_n  = word_r;
        cnt_n   = cnt_r;
        yumi_o  = 1'b0;
        unique case (state)
            IDLE: begin
                yumi_o = v_i;
                if (v_i) begin
                    word_n  = data_i;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (cnt_r == last_idx) begin
                        cnt_n = '0;
                        if (v_i) begin
                            yumi_o = 1'b1;
                            word_n = data_i;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt_r + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        chunk = '0;
        for (int i = 0; i < els_p; i++) begin
            if (int'(cnt_r) == i) begin
`ifdef FIFO_SERIALIZE_DRAIN_MSB_FIRST_EN
                chunk = word_r[(els_p-1-i)*width_p +: width_p];
`else
                chunk = word_r[i*width_p +: width_p];
`endif
            end
        end
    end

    assign send   = (state == SEND);
    assign v_o    = send;
    assign last_o = send && (cnt_r == last_idx);
    assign data_o = send ? chunk : '0;

endmodule
